// File: rtl/dmem_pkg.sv
// Shared encodings for the parametrised data memory: access types, functions
// and the request-sequencing state.
package dmem_pkg;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  typedef enum logic {IDLE, WAIT} state_t;

endpackage

// File: rtl/param_dmem_if.sv
// DMEM request/response bus between the core (master) and the data memory (slave).
interface param_dmem_if;

  logic [31:0] dmem_in_io_dmem_req_bits_addr;
  logic [31:0] dmem_in_io_dmem_req_bits_data;
  logic        dmem_in_io_dmem_req_bits_fcn;
  logic [2:0]  dmem_in_io_dmem_req_bits_typ;
  logic        dmem_in_io_dmem_req_valid;
  logic        dmem_ou_io_dmem_req_ready;
  logic        dmem_ou_io_dmem_resp_valid;
  logic [31:0] dmem_ou_io_dmem_resp_bits_data;
  logic        dmem_ou_io_dmem_resp_bits_err;

  modport master (
    output dmem_in_io_dmem_req_bits_addr,
    output dmem_in_io_dmem_req_bits_data,
    output dmem_in_io_dmem_req_bits_fcn,
    output dmem_in_io_dmem_req_bits_typ,
    output dmem_in_io_dmem_req_valid,
    input  dmem_ou_io_dmem_req_ready,
    input  dmem_ou_io_dmem_resp_valid,
    input  dmem_ou_io_dmem_resp_bits_data,
    input  dmem_ou_io_dmem_resp_bits_err
  );

  modport slave (
    input  dmem_in_io_dmem_req_bits_addr,
    input  dmem_in_io_dmem_req_bits_data,
    input  dmem_in_io_dmem_req_bits_fcn,
    input  dmem_in_io_dmem_req_bits_typ,
    input  dmem_in_io_dmem_req_valid,
    output dmem_ou_io_dmem_req_ready,
    output dmem_ou_io_dmem_resp_valid,
    output dmem_ou_io_dmem_resp_bits_data,
    output dmem_ou_io_dmem_resp_bits_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational sub-word handling: load extraction with sign/zero extension,
// store lane merging, and misalignment / invalid-type detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  typ,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        err
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val   = word[7:0];
    half_val   = offset[1] ? word[31:16] : word[15:0];
    load_data  = 32'd0;
    store_word = word;
    err        = 1'b0;

    case (offset)
      2'd0: byte_val = word[7:0];
      2'd1: byte_val = word[15:8];
      2'd2: byte_val = word[23:16];
      2'd3: byte_val = word[31:24];
      default: byte_val = word[7:0];
    endcase

    case (typ)
      MT_B, MT_BU: err = 1'b0;
      MT_H, MT_HU: err = offset[0];
      MT_W:        err = (offset != 2'd0);
      default:     err = 1'b1;
    endcase

    case (typ)
      MT_B:    load_data = {{24{byte_val[7]}}, byte_val};
      MT_BU:   load_data = {24'd0, byte_val};
      MT_H:    load_data = {{16{half_val[15]}}, half_val};
      MT_HU:   load_data = {16'd0, half_val};
      MT_W:    load_data = word;
      default: load_data = 32'd0;
    endcase

    // Unsigned store types write exactly like their signed counterparts.
    case (typ)
      MT_B, MT_BU: begin
        case (offset)
          2'd0: store_word = {word[31:8], store_data[7:0]};
          2'd1: store_word = {word[31:16], store_data[7:0], word[7:0]};
          2'd2: store_word = {word[31:24], store_data[7:0], word[15:0]};
          2'd3: store_word = {store_data[7:0], word[23:0]};
          default: store_word = word;
        endcase
      end
      MT_H, MT_HU: store_word = offset[1] ? {store_data[15:0], word[15:0]}
                                          : {word[31:16], store_data[15:0]};
      MT_W:        store_word = store_data;
      default:     store_word = word;
    endcase
  end

endmodule

// File: rtl/param_dmem.sv
// Parametrised DMEM: configurable depth, wait states and handshake style,
// with sub-word loads/stores and error reporting on the response.
module param_dmem
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS    = 6,
  parameter int DELAY_CYCLES = 0,
  parameter int HS_MODE      = 0
) (
  input  logic         clock,
  input  logic         reset,
  param_dmem_if.slave  bus
);

  localparam int         IDX_BITS = ADDR_BITS - 2;
  localparam int         DEPTH    = 1 << IDX_BITS;
  localparam logic [3:0] DELAY    = 4'(DELAY_CYCLES);

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [31:0]            lat_data;
  logic                   lat_fcn;
  logic [2:0]             lat_typ;
  logic                   resp_valid;
  logic [31:0]            resp_data;
  logic                   resp_err;

  logic [31:0]            mem [DEPTH];

  logic                   ready;
  logic                   accept;
  logic                   access;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [31:0]            acc_data;
  logic                   acc_fcn;
  logic [2:0]             acc_typ;
  logic [31:0]            acc_word;
  logic [31:0]            load_data;
  logic [31:0]            store_word;
  logic                   acc_err;

  wire unused_addr_hi = ^bus.dmem_in_io_dmem_req_bits_addr[31:ADDR_BITS];

  assign ready  = (HS_MODE == 0) ? (state == IDLE) : (state == IDLE && !resp_valid);
  assign accept = bus.dmem_in_io_dmem_req_valid && ready;

  // With no wait states the access happens on the accepting edge from the live
  // request; otherwise it always comes from the latched copy.
  assign acc_addr = (DELAY_CYCLES == 0) ? bus.dmem_in_io_dmem_req_bits_addr[ADDR_BITS-1:0] : lat_addr;
  assign acc_data = (DELAY_CYCLES == 0) ? bus.dmem_in_io_dmem_req_bits_data : lat_data;
  assign acc_fcn  = (DELAY_CYCLES == 0) ? bus.dmem_in_io_dmem_req_bits_fcn  : lat_fcn;
  assign acc_typ  = (DELAY_CYCLES == 0) ? bus.dmem_in_io_dmem_req_bits_typ  : lat_typ;
  assign access   = (DELAY_CYCLES == 0) ? (state == IDLE && accept)
                                        : (state == WAIT && cnt == DELAY);

  assign acc_word = mem[acc_addr[ADDR_BITS-1:2]];

  dmem_lane_align u_align (
    .word       (acc_word),
    .store_data (acc_data),
    .offset     (acc_addr[1:0]),
    .typ        (acc_typ),
    .load_data  (load_data),
    .store_word (store_word),
    .err        (acc_err)
  );

  // Memory is deliberately unreset; reset only suppresses a pending write.
  always_ff @(posedge clock) begin
    if (!reset && access && acc_fcn == M_XWR && !acc_err)
      mem[acc_addr[ADDR_BITS-1:2]] <= store_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_addr   <= '0;
      lat_data   <= 32'd0;
      lat_fcn    <= M_XRD;
      lat_typ    <= MT_X;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (access) begin
        resp_valid <= 1'b1;
        resp_data  <= (acc_err || acc_fcn == M_XWR) ? 32'd0 : load_data;
        resp_err   <= acc_err;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr <= bus.dmem_in_io_dmem_req_bits_addr[ADDR_BITS-1:0];
            lat_data <= bus.dmem_in_io_dmem_req_bits_data;
            lat_fcn  <= bus.dmem_in_io_dmem_req_bits_fcn;
            lat_typ  <= bus.dmem_in_io_dmem_req_bits_typ;
            if (DELAY_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == DELAY) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.dmem_ou_io_dmem_req_ready      = ready;
  assign bus.dmem_ou_io_dmem_resp_valid     = resp_valid;
  assign bus.dmem_ou_io_dmem_resp_bits_data = resp_data;
  assign bus.dmem_ou_io_dmem_resp_bits_err  = resp_err;

endmodule

// File: tb/tb_param_dmem.sv
// Directed bench: a zero-wait 3-stage instance driven from a vector table, and a
// 3-wait-state 5-stage instance exercised with hand-written latency/reset sequences.
module tb_param_dmem;
  import dmem_pkg::*;

  logic clock;
  logic reset0;
  logic reset1;

  int vec_count  = 0;
  int miscompares = 0;

  param_dmem_if bus0 ();
  param_dmem_if bus1 ();

  param_dmem #(.ADDR_BITS(6), .DELAY_CYCLES(0), .HS_MODE(0)) dut0 (
    .clock (clock),
    .reset (reset0),
    .bus   (bus0.slave)
  );

  param_dmem #(.ADDR_BITS(6), .DELAY_CYCLES(3), .HS_MODE(1)) dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        fcn;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s #%0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus0.dmem_in_io_dmem_req_bits_fcn  = v.fcn;
    bus0.dmem_in_io_dmem_req_bits_typ  = v.typ;
    bus0.dmem_in_io_dmem_req_bits_addr = v.addr;
    bus0.dmem_in_io_dmem_req_bits_data = v.data;
    bus0.dmem_in_io_dmem_req_valid     = 1'b1;
  endtask

  // One request on the wait-state instance; the request lines are scrambled while
  // it waits, and the response must arrive exactly four cycles after acceptance.
  task automatic dut1_txn(input int idx, input logic fcn, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_err);
    int lat;
    lat = 0;
    check_output("dut1_ready_before", idx, {31'd0, bus1.dmem_ou_io_dmem_req_ready}, 32'd1);
    bus1.dmem_in_io_dmem_req_bits_fcn  = fcn;
    bus1.dmem_in_io_dmem_req_bits_typ  = typ;
    bus1.dmem_in_io_dmem_req_bits_addr = addr;
    bus1.dmem_in_io_dmem_req_bits_data = data;
    bus1.dmem_in_io_dmem_req_valid     = 1'b1;
    @(posedge clock); #1;
    bus1.dmem_in_io_dmem_req_bits_fcn  = M_XWR;
    bus1.dmem_in_io_dmem_req_bits_typ  = MT_W;
    bus1.dmem_in_io_dmem_req_bits_addr = addr;
    bus1.dmem_in_io_dmem_req_bits_data = 32'hFFFF_FFFF;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin
        @(posedge clock); #1;
      end
      check_output("dut1_ready_blocked", idx, {31'd0, bus1.dmem_ou_io_dmem_req_ready}, 32'd0);
      if (bus1.dmem_ou_io_dmem_resp_valid) begin
        lat = c;
        break;
      end
    end
    bus1.dmem_in_io_dmem_req_valid = 1'b0;
    check_output("dut1_latency", idx, lat, 32'd4);
    check_output("dut1_data", idx, bus1.dmem_ou_io_dmem_resp_bits_data, exp_data);
    check_output("dut1_err", idx, {31'd0, bus1.dmem_ou_io_dmem_resp_bits_err}, {31'd0, exp_err});
    @(posedge clock); #1;
    check_output("dut1_pulse_end", idx, {31'd0, bus1.dmem_ou_io_dmem_resp_valid}, 32'd0);
    check_output("dut1_ready_after", idx, {31'd0, bus1.dmem_ou_io_dmem_req_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{M_XWR, MT_W,  32'h08, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{M_XRD, MT_W,  32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{M_XRD, MT_B,  32'h0B, 32'h0,         32'hFFFF_FFDE, 1'b0};
    vecs[3]  = '{M_XRD, MT_BU, 32'h0B, 32'h0,         32'h0000_00DE, 1'b0};
    vecs[4]  = '{M_XRD, MT_H,  32'h0A, 32'h0,         32'hFFFF_DEAD, 1'b0};
    vecs[5]  = '{M_XRD, MT_HU, 32'h08, 32'h0,         32'h0000_BEEF, 1'b0};
    vecs[6]  = '{M_XWR, MT_B,  32'h09, 32'h55,        32'h0000_0000, 1'b0};
    vecs[7]  = '{M_XRD, MT_W,  32'h08, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[8]  = '{M_XRD, MT_W,  32'h06, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{M_XWR, MT_H,  32'h09, 32'h1234,      32'h0000_0000, 1'b1};
    vecs[10] = '{M_XRD, 3'd4,  32'h08, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{M_XRD, MT_W,  32'h08, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[12] = '{M_XRD, MT_W,  32'h48, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[13] = '{M_XWR, MT_HU, 32'h0A, 32'hFFFF_ABCD, 32'h0000_0000, 1'b0};
    vecs[14] = '{M_XRD, MT_W,  32'h08, 32'h0,         32'hABCD_55EF, 1'b0};
    vecs[15] = '{M_XRD, MT_H,  32'h08, 32'h0,         32'h0000_55EF, 1'b0};
    vecs[16] = '{M_XRD, MT_B,  32'h08, 32'h0,         32'hFFFF_FFEF, 1'b0};
    vecs[17] = '{M_XWR, 3'd7,  32'h08, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[18] = '{M_XRD, MT_X,  32'h08, 32'h0,         32'h0000_0000, 1'b1};
    vecs[19] = '{M_XRD, MT_W,  32'h08, 32'h0,         32'hABCD_55EF, 1'b0};

    bus0.dmem_in_io_dmem_req_valid     = 1'b0;
    bus0.dmem_in_io_dmem_req_bits_fcn  = M_XRD;
    bus0.dmem_in_io_dmem_req_bits_typ  = MT_W;
    bus0.dmem_in_io_dmem_req_bits_addr = 32'd0;
    bus0.dmem_in_io_dmem_req_bits_data = 32'd0;
    bus1.dmem_in_io_dmem_req_valid     = 1'b0;
    bus1.dmem_in_io_dmem_req_bits_fcn  = M_XRD;
    bus1.dmem_in_io_dmem_req_bits_typ  = MT_W;
    bus1.dmem_in_io_dmem_req_bits_addr = 32'd0;
    bus1.dmem_in_io_dmem_req_bits_data = 32'd0;
    reset0 = 1'b1;
    reset1 = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset0 = 1'b0;
    reset1 = 1'b0;

    check_output("rst0_resp_valid", 0, {31'd0, bus0.dmem_ou_io_dmem_resp_valid}, 32'd0);
    check_output("rst0_resp_data",  0, bus0.dmem_ou_io_dmem_resp_bits_data, 32'd0);
    check_output("rst0_resp_err",   0, {31'd0, bus0.dmem_ou_io_dmem_resp_bits_err}, 32'd0);
    check_output("rst0_ready",      0, {31'd0, bus0.dmem_ou_io_dmem_req_ready}, 32'd1);
    check_output("rst1_resp_valid", 0, {31'd0, bus1.dmem_ou_io_dmem_resp_valid}, 32'd0);
    check_output("rst1_ready",      0, {31'd0, bus1.dmem_ou_io_dmem_req_ready}, 32'd1);

    // Back-to-back accepts: every vector's response must appear right after its edge.
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output("vec_ready", i, {31'd0, bus0.dmem_ou_io_dmem_req_ready}, 32'd1);
      @(posedge clock); #1;
      check_output("vec_resp_valid", i, {31'd0, bus0.dmem_ou_io_dmem_resp_valid}, 32'd1);
      check_output("vec_data", i, bus0.dmem_ou_io_dmem_resp_bits_data, vecs[i].exp_data);
      check_output("vec_err", i, {31'd0, bus0.dmem_ou_io_dmem_resp_bits_err}, {31'd0, vecs[i].exp_err});
    end
    bus0.dmem_in_io_dmem_req_valid = 1'b0;
    @(posedge clock); #1;
    check_output("idle_resp_valid", NVEC, {31'd0, bus0.dmem_ou_io_dmem_resp_valid}, 32'd0);
    check_output("idle_data_hold",  NVEC, bus0.dmem_ou_io_dmem_resp_bits_data, 32'hABCD_55EF);
    check_output("idle_err_hold",   NVEC, {31'd0, bus0.dmem_ou_io_dmem_resp_bits_err}, 32'd0);

    dut1_txn(100, M_XWR, MT_W, 32'h10, 32'h1122_3344, 32'h0000_0000, 1'b0);
    dut1_txn(101, M_XRD, MT_W, 32'h10, 32'h0,         32'h1122_3344, 1'b0);
    dut1_txn(102, M_XRD, MT_H, 32'h13, 32'h0,         32'h0000_0000, 1'b1);

    // Reset lands while the write waits at cnt==2 and stays through its access edge.
    bus1.dmem_in_io_dmem_req_bits_fcn  = M_XWR;
    bus1.dmem_in_io_dmem_req_bits_typ  = MT_W;
    bus1.dmem_in_io_dmem_req_bits_addr = 32'h10;
    bus1.dmem_in_io_dmem_req_bits_data = 32'hCAFE_F00D;
    bus1.dmem_in_io_dmem_req_valid     = 1'b1;
    @(posedge clock); #1;
    bus1.dmem_in_io_dmem_req_valid = 1'b0;
    @(posedge clock); #1;
    reset1 = 1'b1;
    @(posedge clock); #1;
    check_output("rstwait_resp_a", 200, {31'd0, bus1.dmem_ou_io_dmem_resp_valid}, 32'd0);
    @(posedge clock); #1;
    check_output("rstwait_resp_b", 200, {31'd0, bus1.dmem_ou_io_dmem_resp_valid}, 32'd0);
    reset1 = 1'b0;
    @(posedge clock); #1;
    check_output("rstwait_resp_c", 200, {31'd0, bus1.dmem_ou_io_dmem_resp_valid}, 32'd0);
    check_output("rstwait_ready",  200, {31'd0, bus1.dmem_ou_io_dmem_req_ready}, 32'd1);

    dut1_txn(201, M_XRD, MT_W, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
    dut1_txn(202, M_XRD, MT_W, 32'h50, 32'h0, 32'h1122_3344, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/param_dmem.md
# param_dmem

Parametrised data-memory model for Sodor security verification: the successor to the fixed 16-word single-cycle DMEM. Adds configurable depth, programmable wait states, and selectable 3-stage/5-stage handshake. Adds signed/unsigned sub-word loads and misalignment/invalid-type error reporting. Sits on the core's DMEM request/response bus in place of the simple DMEM in formal and simulation harnesses.

## Interface
Parameters:
- ADDR_BITS, 6, byte-address bits decoded; depth = 2**(ADDR_BITS-2) words; addr bits above ADDR_BITS-1 ignored (aliasing)
- DELAY_CYCLES, 0, wait states between acceptance and access, 0..15
- HS_MODE, 0, 0 = 3-stage style (back-to-back accepts), 1 = 5-stage style (no accept in a cycle where resp_valid=1)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- dmem_in_io_dmem_req_bits_addr  in  32  byte address
- dmem_in_io_dmem_req_bits_data  in  32  store data, LSB-aligned
- dmem_in_io_dmem_req_bits_fcn  in  1  0 = read, 1 = write
- dmem_in_io_dmem_req_bits_typ  in  3  1 B, 2 H, 3 W, 5 BU, 6 HU
- dmem_in_io_dmem_req_valid  in  1  request valid
- dmem_ou_io_dmem_req_ready  out  1  request accepted when valid&ready at clock edge
- dmem_ou_io_dmem_resp_valid  out  1  one-cycle response pulse
- dmem_ou_io_dmem_resp_bits_data  out  32  load result; 0 for writes and errors
- dmem_ou_io_dmem_resp_bits_err  out  1  misaligned or invalid typ; qualified by resp_valid

## Operation
- States: IDLE, WAIT. Counter cnt (4 bits), latched request regs (addr, data, fcn, typ).
- IDLE: accept on valid&ready; latch request. DELAY_CYCLES=0 → access performed at accepting edge, stay IDLE. Else → WAIT, cnt=1.
- WAIT: cnt increments each cycle; at cnt==DELAY_CYCLES access uses latched request, return to IDLE, cnt=0. Live inputs ignored in WAIT.
- ready: HS_MODE 0 → state==IDLE; HS_MODE 1 → state==IDLE && !resp_valid.
- Read: word = mem[addr[ADDR_BITS-1:2]]; B/BU select byte addr[1:0]; H/HU select half addr[1]; B, H sign-extend; BU, HU zero-extend; W full word.
- Write: B merges byte lane addr[1:0]; H merges half lane addr[1]; W full word. Store typ 5/6 behave as 1/2. Other lanes unchanged.
- Error: H/HU with addr[0]=1, W with addr[1:0]≠0, or typ ∈ {0,4,7}: no memory write, data=0, err=1.
- Memory array not reset; contents persist across reset. Initial contents undefined (formal: free).

## Timing
- Reset values: resp_valid=0, resp_bits_data=0, resp_bits_err=0, state=IDLE, cnt=0. req_ready combinational from state, so 1 in cycle after reset.
- Latency: accept at edge k → resp_valid high during cycle k+1+DELAY_CYCLES, exactly one cycle.
- HS_MODE 0, DELAY 0: full throughput, one response per accepted request, in order.
- HS_MODE 1: minimum two cycles between accepts (accept, response cycle blocked).
- Read-after-write to same word on consecutive accepts returns new data (write committed at access edge).
- Reset during WAIT: request dropped, no write, no response; reset dominates a simultaneous access edge.
- resp_bits_data/err hold last values when resp_valid=0.

## Structure
- Package dmem_pkg: typ constants MT_X=0, MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6; fcn M_XRD=0, M_XWR=1; state enum {IDLE, WAIT}.
- Sub-module dmem_lane_align (combinational): inputs word, store data, offset, typ; outputs extracted load value, merged store word, err.
- Top holds array, FSM, counter, request latches, output regs.

## Test plan
- DELAY 0, HS 0: W write 0xDEADBEEF @0x8, W read @0x8 next cycle → resp 0xDEADBEEF, err=0, resp_valid one cycle after each accept.
- Byte/half: after above, B read @0xB → 0xFFFFFFDE; BU @0xB → 0x000000DE; H @0xA → 0xFFFFDEAD; HU @0x8 → 0x0000BEEF.
- Merge: B write 0x55 @0x9 then W read @0x8 → 0xDEAD55EF.
- Errors: W read @0x6, H write @0x9, typ 4 → err=1, data 0, memory @0x8 unchanged.
- DELAY 3, HS 1: accept at edge k, resp_valid at k+4 only; ready=0 cycles k+1..k+4; inputs changed in WAIT ignored.
- Reset asserted at cnt=2 of a W write: no resp_valid, subsequent read shows old value; aliasing: read @0x48 with ADDR_BITS=6 returns word @0x8.
